// File: rtl/amiga_cycle_ctl_pkg.sv
// ---------------------------------------------------------------------------
// amiga_cycle_ctl_pkg
// Shared definitions for the AmigaPCI cycle controller and the bus-sizing
// stage that feeds it.
//   LANES       : number of byte-lane strobes (nDS width)
//   cyc_state_t : cycle controller state enumeration
//   siz_t       : transfer size encodings as driven on SIZ
//   dsack_t     : termination encodings returned to the bus sizer
// ---------------------------------------------------------------------------
package amiga_cycle_ctl_pkg;

   localparam int LANES = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_TERM    = 3'd3,
      ST_RECOVER = 3'd4
   } cyc_state_t;

   typedef enum logic [1:0] {
      LWORD = 2'b00,
      BYTE  = 2'b01,
      WORD  = 2'b10,
      BURST = 2'b11
   } siz_t;

   typedef enum logic [1:0] {
      L_TERM    = 2'b00,
      W_TERM    = 2'b01,
      WAIT_TERM = 2'b11
   } dsack_t;

endpackage

// File: rtl/amiga_cycle_ctl_lane_decode.sv
// ---------------------------------------------------------------------------
// lane_decode
// Combinational byte-lane decode. Produces the active-low lane mask for the
// latched transfer size and low address bits; the parent registers it.
//   SIZ   in  2      transfer size (LWORD/BYTE/WORD/BURST)
//   A     in  2      A[1:0]
//   nLANE out LANES  active-low lane mask, bit0 = D31:24 ... bit3 = D7:0
// ---------------------------------------------------------------------------
module lane_decode
   import amiga_cycle_ctl_pkg::*;
(
   input  logic [1:0]       SIZ,
   input  logic [1:0]       A,
   output logic [LANES-1:0] nLANE
);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         // Byte address that this lane carries (lane 0 is the most
         // significant byte of the long word).
         localparam logic [1:0] LANE_IDX = gi[1:0];

         // Byte: only the addressed lane. Word: the half selected by A[1].
         // Long and burst: all lanes.
         assign nLANE[gi] = (SIZ == BYTE) ? (A != LANE_IDX)
                          : (SIZ == WORD) ? (A[1] != LANE_IDX[1])
                          : 1'b0;
      end
   endgenerate

endmodule

// File: rtl/amiga_cycle_ctl.sv
// ---------------------------------------------------------------------------
// amiga_cycle_ctl
// Runs one AmigaPCI bus cycle per accepted transfer start: SETUP drops nAS,
// STROBE drives the byte lanes and waits for nDTACK / nBERR / timeout, TERM
// returns a one-cycle DSACK (and nTEA on error), RECOVER enforces an idle gap.
// All outputs come straight from flops. Outputs reflect the action of the
// state that was current at the edge, so nAS falls on the SETUP edge.
//   CLK40   in   1  clock
//   nRESET  in   1  synchronous active-low reset
//   nTS     in   1  transfer start, one cycle, only honoured in IDLE
//   RnW     in   1  1 = read, 0 = write (sampled with nTS)
//   SIZ     in   2  transfer size (sampled with nTS)
//   A       in   2  A[1:0] (sampled with nTS)
//   PORT32  in   1  1 = 32-bit target, 0 = 16-bit (sampled with nTS)
//   nDTACK  in   1  async target acknowledge
//   nBERR   in   1  async target bus error
//   nAS     out  1  address strobe
//   nDS     out  4  byte-lane strobes
//   WRITE   out  1  ~RnW of the current cycle
//   DSACK   out  2  termination to the bus sizer (11 = wait)
//   nTEA    out  1  transfer error, only alongside a DSACK termination
//   BUSY    out  1  cycle in progress (accept through end of RECOVER)
// ---------------------------------------------------------------------------
module amiga_cycle_ctl
   import amiga_cycle_ctl_pkg::*;
#(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd200,
   parameter logic [1:0] RECOVER_CYCLES = 2'd1
)
(
   input  logic             CLK40,
   input  logic             nRESET,
   input  logic             nTS,
   input  logic             RnW,
   input  logic [1:0]       SIZ,
   input  logic [1:0]       A,
   input  logic             PORT32,
   input  logic             nDTACK,
   input  logic             nBERR,
   output logic             nAS,
   output logic [LANES-1:0] nDS,
   output logic             WRITE,
   output logic [1:0]       DSACK,
   output logic             nTEA,
   output logic             BUSY
);

   cyc_state_t       state_reg;
   logic [1:0]       siz_reg;
   logic [1:0]       a_reg;
   logic             port32_reg;
   logic             err_reg;
   logic [7:0]       cnt_reg;
   logic [1:0]       rec_cnt_reg;
   logic             nas_reg;
   logic [LANES-1:0] nds_reg;
   logic             write_reg;
   dsack_t           dsack_reg;
   logic             ntea_reg;
   logic             busy_reg;

   // Bit 1 is the synchronized value used by the FSM.
   logic [1:0]       dtack_sync_reg;
   logic [1:0]       berr_sync_reg;

   logic [LANES-1:0] lane_mask;

   lane_decode u_lane_decode (
      .SIZ   (siz_reg),
      .A     (a_reg),
      .nLANE (lane_mask)
   );

   always_ff @(posedge CLK40) begin
      if (!nRESET) begin
         dtack_sync_reg <= 2'b11;
         berr_sync_reg  <= 2'b11;
      end else begin
         dtack_sync_reg <= {dtack_sync_reg[0], nDTACK};
         berr_sync_reg  <= {berr_sync_reg[0], nBERR};
      end
   end

   always_ff @(posedge CLK40) begin
      if (!nRESET) begin
         state_reg   <= ST_IDLE;
         siz_reg     <= 2'b00;
         a_reg       <= 2'b00;
         port32_reg  <= 1'b0;
         err_reg     <= 1'b0;
         cnt_reg     <= 8'd0;
         rec_cnt_reg <= 2'd0;
         nas_reg     <= 1'b1;
         nds_reg     <= '1;
         write_reg   <= 1'b0;
         dsack_reg   <= WAIT_TERM;
         ntea_reg    <= 1'b1;
         busy_reg    <= 1'b0;
      end else begin
         // Termination is a single-cycle pulse; every state but TERM
         // returns the bus sizer to wait.
         dsack_reg <= WAIT_TERM;
         ntea_reg  <= 1'b1;

         case (state_reg)
            ST_IDLE: begin
               if (!nTS) begin
                  siz_reg    <= SIZ;
                  a_reg      <= A;
                  port32_reg <= PORT32;
                  write_reg  <= ~RnW;
                  busy_reg   <= 1'b1;
                  state_reg  <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               nas_reg   <= 1'b0;
               cnt_reg   <= 8'd0;
               err_reg   <= 1'b0;
               state_reg <= ST_STROBE;
            end

            ST_STROBE: begin
               nas_reg <= 1'b0;
               nds_reg <= lane_mask;
               if (cnt_reg != TIMEOUT_CYCLES) begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
               // Error is tested first so a simultaneous acknowledge loses.
               if (!berr_sync_reg[1] || (cnt_reg == TIMEOUT_CYCLES)) begin
                  err_reg   <= 1'b1;
                  state_reg <= ST_TERM;
               end else if (!dtack_sync_reg[1]) begin
                  state_reg <= ST_TERM;
               end
            end

            ST_TERM: begin
               nas_reg     <= 1'b1;
               nds_reg     <= '1;
               dsack_reg   <= (port32_reg || err_reg) ? L_TERM : W_TERM;
               ntea_reg    <= ~err_reg;
               rec_cnt_reg <= 2'd1;
               state_reg   <= ST_RECOVER;
            end

            ST_RECOVER: begin
               // A zero gap still spends one cycle here.
               if (rec_cnt_reg >= RECOVER_CYCLES) begin
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  rec_cnt_reg <= rec_cnt_reg + 2'd1;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign nAS   = nas_reg;
   assign nDS   = nds_reg;
   assign WRITE = write_reg;
   assign DSACK = dsack_reg;
   assign nTEA  = ntea_reg;
   assign BUSY  = busy_reg;

endmodule

// File: tb/tb_amiga_cycle_ctl.sv
// ---------------------------------------------------------------------------
// tb_amiga_cycle_ctl
// Directed bench for amiga_cycle_ctl. A transaction-level model tracks, in
// edge numbers, when each cycle was accepted and on which edge it decided to
// terminate; every output is derived from those edge numbers and checked on
// every falling edge. Literal expectations pin latencies and lane masks.
// ---------------------------------------------------------------------------
module tb_amiga_cycle_ctl;

   localparam int TO = 200;
   localparam int RC = 1;

   logic       CLK40 = 1'b0;
   logic       nRESET;
   logic       nTS;
   logic       RnW;
   logic [1:0] SIZ;
   logic [1:0] A;
   logic       PORT32;
   logic       nDTACK;
   logic       nBERR;
   logic       nAS;
   logic [3:0] nDS;
   logic       WRITE;
   logic [1:0] DSACK;
   logic       nTEA;
   logic       BUSY;

   int n_checks = 0;
   int n_fails  = 0;

   amiga_cycle_ctl #(
      .TIMEOUT_CYCLES (8'(TO)),
      .RECOVER_CYCLES (2'(RC))
   ) dut (
      .CLK40  (CLK40),
      .nRESET (nRESET),
      .nTS    (nTS),
      .RnW    (RnW),
      .SIZ    (SIZ),
      .A      (A),
      .PORT32 (PORT32),
      .nDTACK (nDTACK),
      .nBERR  (nBERR),
      .nAS    (nAS),
      .nDS    (nDS),
      .WRITE  (WRITE),
      .DSACK  (DSACK),
      .nTEA   (nTEA),
      .BUSY   (BUSY)
   );

   always #5 CLK40 = ~CLK40;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Lane mask from the size rules: byte clears lane A, word clears the
   // pair selected by A[1], long/burst clears all lanes.
   function automatic logic [3:0] exp_mask(input logic [1:0] siz, input logic [1:0] addr);
      logic [3:0] m;
      m = 4'b1111;
      case (siz)
         2'b01: m[addr] = 1'b0;
         2'b10: begin
            m[{addr[1], 1'b0}] = 1'b0;
            m[{addr[1], 1'b1}] = 1'b0;
         end
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // ---------------- transaction-level model ----------------
   int         e_cnt     = 0;
   logic       model_ok  = 1'b0;
   logic       active    = 1'b0;
   logic       have_term = 1'b0;
   int         a_m       = 0;
   int         m_m       = 0;
   int         idle_from = 0;
   logic       err_m     = 1'b0;
   logic       port32_m  = 1'b0;
   logic       write_m   = 1'b0;
   logic [3:0] mask_m    = 4'hF;
   logic       dt_h [8];
   logic       be_h [8];

   int exp_nas   = 1;
   int exp_nds   = 15;
   int exp_write = 0;
   int exp_dsack = 3;
   int exp_ntea  = 1;
   int exp_busy  = 0;

   always @(posedge CLK40) begin
      int strobe_n;
      e_cnt++;
      dt_h[e_cnt % 8] = nDTACK;
      be_h[e_cnt % 8] = nBERR;
      if (!nRESET) begin
         model_ok  = 1'b1;
         active    = 1'b0;
         have_term = 1'b0;
         write_m   = 1'b0;
         idle_from = e_cnt + 1;
      end else if (model_ok) begin
         if (!active && e_cnt >= idle_from && !nTS) begin
            active    = 1'b1;
            have_term = 1'b0;
            a_m       = e_cnt;
            port32_m  = PORT32;
            write_m   = ~RnW;
            mask_m    = exp_mask(SIZ, A);
         end else if (active && !have_term && e_cnt >= a_m + 2) begin
            // Strobe edges start two edges after accept; inputs reach the
            // decision two edges after being sampled.
            strobe_n = e_cnt - (a_m + 2);
            if (be_h[(e_cnt - 2) % 8] == 1'b0 || strobe_n == TO) begin
               have_term = 1'b1;
               m_m       = e_cnt;
               err_m     = 1'b1;
            end else if (dt_h[(e_cnt - 2) % 8] == 1'b0) begin
               have_term = 1'b1;
               m_m       = e_cnt;
               err_m     = 1'b0;
            end
         end
         if (active && have_term && e_cnt >= m_m + 1 + RC) begin
            active    = 1'b0;
            idle_from = e_cnt + 1;
         end
      end
      exp_nas   = (active && e_cnt >= a_m + 1 && (!have_term || e_cnt <= m_m)) ? 0 : 1;
      exp_nds   = (active && e_cnt >= a_m + 2 && (!have_term || e_cnt <= m_m)) ? int'(mask_m) : 15;
      exp_dsack = (active && have_term && e_cnt == m_m + 1) ? ((port32_m || err_m) ? 0 : 1) : 3;
      exp_ntea  = (active && have_term && e_cnt == m_m + 1 && err_m) ? 0 : 1;
      exp_busy  = (active && (!have_term || e_cnt <= m_m + RC)) ? 1 : 0;
      exp_write = int'(write_m);
   end

   always @(negedge CLK40) begin
      if (model_ok) begin
         chk("nAS",   int'(nAS),   exp_nas);
         chk("nDS",   int'(nDS),   exp_nds);
         chk("WRITE", int'(WRITE), exp_write);
         chk("DSACK", int'(DSACK), exp_dsack);
         chk("nTEA",  int'(nTEA),  exp_ntea);
         chk("BUSY",  int'(BUSY),  exp_busy);
      end
   end

   // ---------------- stimulus ----------------
   // dly < 0 means the target never responds.
   task automatic do_cycle(input logic rnw, input logic [1:0] siz, input logic [1:0] addr,
                           input logic p32, input int dly, input logic dtk, input logic berr,
                           input logic pulse, output int lat, output int nds_seen,
                           output int ds_seen, output int tea_seen);
      int k;
      int guard;
      nds_seen = -1;
      guard = 0;
      while (BUSY !== 1'b0 && guard < 50) begin
         @(negedge CLK40);
         guard++;
      end
      RnW = rnw; SIZ = siz; A = addr; PORT32 = p32; nTS = 1'b0;
      @(negedge CLK40);
      nTS = 1'b1;
      k = 0;
      guard = 0;
      while (nAS !== 1'b0 && guard < 20) begin
         @(negedge CLK40);
         k++;
         guard++;
      end
      chk("nas_latency", k, 1);
      if (dly >= 0) begin
         for (int i = 0; i < dly; i++) begin
            nTS = !(pulse && i == 0);
            @(negedge CLK40);
            k++;
         end
         nTS    = 1'b1;
         nDTACK = ~dtk;
         nBERR  = ~berr;
      end
      guard = 0;
      while (DSACK === 2'b11 && guard < 400) begin
         nds_seen = int'(nDS);
         @(negedge CLK40);
         k++;
         guard++;
      end
      lat      = k;
      ds_seen  = int'(DSACK);
      tea_seen = int'(nTEA);
      nDTACK = 1'b1;
      nBERR  = 1'b1;
      @(negedge CLK40);
      chk("dsack_one_cycle", int'(DSACK), 3);
   endtask

   initial begin
      int lat, nds_s, ds_s, tea_s;
      int tea_low;
      logic [1:0] addr_v;
      logic [3:0] byte_exp [4];
      byte_exp[0] = 4'b1110; byte_exp[1] = 4'b1101;
      byte_exp[2] = 4'b1011; byte_exp[3] = 4'b0111;

      nRESET = 1'b0; nTS = 1'b1; RnW = 1'b1; SIZ = 2'b00; A = 2'b00;
      PORT32 = 1'b0; nDTACK = 1'b1; nBERR = 1'b1;
      repeat (3) @(negedge CLK40);
      chk("rst_nAS",   int'(nAS),   1);
      chk("rst_nDS",   int'(nDS),   15);
      chk("rst_DSACK", int'(DSACK), 3);
      chk("rst_nTEA",  int'(nTEA),  1);
      chk("rst_BUSY",  int'(BUSY),  0);
      chk("rst_WRITE", int'(WRITE), 0);
      nRESET = 1'b1;
      @(negedge CLK40);

      // long read to 32-bit port, acknowledge two cycles into STROBE
      do_cycle(1'b1, 2'b00, 2'b00, 1'b1, 2, 1'b1, 1'b0, 1'b0, lat, nds_s, ds_s, tea_s);
      $display("txn long32 read: lat=%0d nDS=%0h DSACK=%0d nTEA=%0d", lat, nds_s, ds_s, tea_s);
      chk("long32_lat", lat, 7);
      chk("long32_nds", nds_s, 0);
      chk("long32_dsack", ds_s, 0);
      chk("long32_ntea", tea_s, 1);
      chk("long32_write", int'(WRITE), 0);

      // long write to 16-bit port, immediate acknowledge: minimum latency
      do_cycle(1'b0, 2'b00, 2'b00, 1'b0, 0, 1'b1, 1'b0, 1'b0, lat, nds_s, ds_s, tea_s);
      $display("txn long16 upper: lat=%0d nDS=%0h DSACK=%0d nTEA=%0d", lat, nds_s, ds_s, tea_s);
      chk("long16_lat", lat, 5);
      chk("long16_dsack", ds_s, 1);
      chk("long16_write", int'(WRITE), 1);
      do_cycle(1'b0, 2'b00, 2'b10, 1'b0, 0, 1'b1, 1'b0, 1'b0, lat, nds_s, ds_s, tea_s);
      $display("txn long16 lower: lat=%0d nDS=%0h DSACK=%0d nTEA=%0d", lat, nds_s, ds_s, tea_s);
      chk("long16b_dsack", ds_s, 1);
      chk("long16b_nds", nds_s, 0);

      // byte lanes
      for (int i = 0; i < 4; i++) begin
         addr_v = 2'(i);
         do_cycle(1'b1, 2'b01, addr_v, 1'b1, 1, 1'b1, 1'b0, 1'b0, lat, nds_s, ds_s, tea_s);
         $display("txn byte A=%0d: lat=%0d nDS=%0h DSACK=%0d", i, lat, nds_s, ds_s);
         chk("byte_nds", nds_s, int'(byte_exp[i]));
      end

      // word lanes
      do_cycle(1'b1, 2'b10, 2'b10, 1'b0, 0, 1'b1, 1'b0, 1'b0, lat, nds_s, ds_s, tea_s);
      $display("txn word A=2: nDS=%0h DSACK=%0d", nds_s, ds_s);
      chk("word_hi_nds", nds_s, 4'b0011);
      chk("word_hi_dsack", ds_s, 1);
      do_cycle(1'b1, 2'b10, 2'b00, 1'b0, 0, 1'b1, 1'b0, 1'b0, lat, nds_s, ds_s, tea_s);
      $display("txn word A=0: nDS=%0h DSACK=%0d", nds_s, ds_s);
      chk("word_lo_nds", nds_s, 4'b1100);

      // no acknowledge: timeout
      do_cycle(1'b1, 2'b11, 2'b00, 1'b0, -1, 1'b0, 1'b0, 1'b0, lat, nds_s, ds_s, tea_s);
      $display("txn timeout: lat=%0d DSACK=%0d nTEA=%0d", lat, ds_s, tea_s);
      chk("timeout_lat", lat, TO + 3);
      chk("timeout_dsack", ds_s, 0);
      chk("timeout_ntea", tea_s, 0);

      // error and acknowledge together on a 16-bit port
      do_cycle(1'b0, 2'b00, 2'b00, 1'b0, 1, 1'b1, 1'b1, 1'b0, lat, nds_s, ds_s, tea_s);
      $display("txn berr+dtack: lat=%0d DSACK=%0d nTEA=%0d", lat, ds_s, tea_s);
      chk("berr_dsack", ds_s, 0);
      chk("berr_ntea", tea_s, 0);

      // nTS pulsed during STROBE must not start another cycle
      do_cycle(1'b1, 2'b00, 2'b00, 1'b1, 3, 1'b1, 1'b0, 1'b1, lat, nds_s, ds_s, tea_s);
      $display("txn nts_in_strobe: lat=%0d DSACK=%0d", lat, ds_s);
      chk("pulse_lat", lat, 8);
      repeat (8) @(negedge CLK40);
      chk("pulse_no_extra_busy", int'(BUSY), 0);
      chk("pulse_no_extra_nas", int'(nAS), 1);

      // reset during STROBE
      RnW = 1'b0; SIZ = 2'b00; A = 2'b00; PORT32 = 1'b1; nTS = 1'b0;
      @(negedge CLK40);
      nTS = 1'b1;
      repeat (3) @(negedge CLK40);
      chk("abort_nas_before", int'(nAS), 0);
      nRESET = 1'b0;
      @(negedge CLK40);
      nRESET = 1'b1;
      $display("txn reset_abort: nAS=%0d nDS=%0h DSACK=%0d nTEA=%0d BUSY=%0d", nAS, nDS, DSACK, nTEA, BUSY);
      chk("abort_nas", int'(nAS), 1);
      chk("abort_nds", int'(nDS), 15);
      chk("abort_dsack", int'(DSACK), 3);
      chk("abort_ntea", int'(nTEA), 1);
      chk("abort_busy", int'(BUSY), 0);
      tea_low = 0;
      repeat (10) begin
         @(negedge CLK40);
         if (nTEA == 1'b0 || DSACK != 2'b11) tea_low++;
      end
      chk("abort_no_term_pulse", tea_low, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
